tt3_sweep_checker: RTL and testbench

Sequential stimulus/response stage that wraps a 3-input combinational gate-level circuit under test, such as the NOT/NOR netlists produced for truth table 0xB2. It sits directly upstream of the circuit, driving `in1`/`in2`/`in3` through all 8 input rows. It also sits directly downstream, sampling `out` after a settle window, packing the responses into an 8-bit truth table and comparing it against the expected function. It is used in circuit score testing to confirm that a synthesized netlist implements its target hex function.

---
 rtl/tt3_sweep_checker.sv | 148 ++++++++++++++
 tb/tb_tt3_sweep_checker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tt3_sweep_checker.sv
// Truth-table sweep checker for a 3-input combinational circuit: drives all 8 rows,
// samples the response after a settle window and compares it with TRUTH_TABLE.
// Optional macro TT3_SWEEP_SYNC_EN adds a 2-flop synchronizer on dut_out.
module tt3_sweep_checker #(
  parameter logic [7:0] TRUTH_TABLE   = 8'hB2,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [3:0] mismatch_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

`ifdef TT3_SWEEP_SYNC_EN
  localparam int W = SETTLE_CYCLES + 2;
`else
  localparam int W = SETTLE_CYCLES;
`endif
  // Nine bits so the largest window (255 + 2 - 1) still fits.
  localparam logic [8:0] RELOAD = 9'(W - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [8:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] cap_q, cap_d;
  logic [3:0] mis_q, mis_d;
  logic       sample_bit;
  logic [2:0] bit_idx;
  logic       row_differs;

`ifdef TT3_SWEEP_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= dut_out;
      sync2_q <= sync1_q;
    end
  end

  assign sample_bit = sync2_q;
`else
  assign sample_bit = dut_out;
`endif

  // Row r lives at bit 7-r, which for a 3-bit index is just the bitwise inverse.
  assign bit_idx     = ~row_q;
  assign row_differs = sample_bit ^ TRUTH_TABLE[bit_idx];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    cap_d   = cap_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = 3'd0;
          cap_d   = 8'h00;
          mis_d   = 4'd0;
          pass_d  = 1'b0;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 9'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 9'd1;
      end
      S_SAMPLE: begin
        cap_d[bit_idx] = sample_bit;
        mis_d          = mis_q + {3'b000, row_differs};
        if (row_q != 3'd7) begin
          row_d   = row_q + 3'd1;
          cnt_d   = RELOAD;
          state_d = S_SETTLE;
        end else begin
          // Flags are registered so they are visible during the DONE cycle.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (mis_d == 4'd0);
          state_d = S_DONE;
        end
      end
      default: begin
        row_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= 3'd0;
      cnt_q   <= 9'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cap_q   <= 8'h00;
      mis_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cap_q   <= cap_d;
      mis_q   <= mis_d;
    end
  end

  // The row register directly drives the circuit inputs.
  assign in1            = row_q[2];
  assign in2            = row_q[1];
  assign in3            = row_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign captured       = cap_q;
  assign mismatch_count = mis_q;

endmodule

// File: tb/tb_tt3_sweep_checker.sv
// Directed bench for tt3_sweep_checker with a behavioural 3-input circuit model
// (good 0xB2, stuck-at-0, row-7 inverted).
module tb_tt3_sweep_checker;

`ifdef TT3_SWEEP_SYNC_EN
  localparam int W = 6;
`else
  localparam int W = 4;
`endif
  localparam int LAT = 8 * (W + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_out;
  logic       in1, in2, in3;
  logic       busy, done, pass;
  logic [7:0] captured;
  logic [3:0] mismatch_count;

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  logic [7:0] model_tt;
  logic [2:0] row_in;

  tt3_sweep_checker #(.TRUTH_TABLE(8'hB2), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done), .pass(pass),
    .captured(captured), .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  // Circuit model: 0 = correct 0xB2, 1 = stuck-at-0, 2 = row 7 inverted.
  assign row_in = {in1, in2, in3};
  always_comb begin
    model_tt = 8'hB2;
    dut_out  = model_tt[3'd7 - row_in];
    if (mode == 1) dut_out = 1'b0;
    if (mode == 2 && row_in == 3'd7) dut_out = ~dut_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then counts edges after the accepting edge until done is seen.
  // restart_at: cycle at which to pulse start again; rst_at: cycle to reset (0 = never).
  task automatic run(input int restart_at, input int rst_at, output int n);
    bit found = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == restart_at);
      if (n == 1) begin
        check("busy_after_start", busy, 1);
        check("pass_cleared", pass, 0);
        check("captured_cleared", captured, 0);
        check("mis_cleared", mismatch_count, 0);
      end
      if (n == 3 * (W + 1) + 1) check("row3_inputs", row_in, 3'd3);
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_captured", captured, 0);
        check("rst_inputs", row_in, 0);
        check("rst_mis", mismatch_count, 0);
        check("rst_done", done, 0);
        @(negedge clk) rst = 1'b0;
        n = -2;
        return;
      end
      if (done) found = 1;
    end
    if (!found) n = -1;
    start = 1'b0;
  endtask

  int n;
  int extra_done;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_captured", captured, 0);
    check("reset_mis", mismatch_count, 0);
    check("reset_inputs", row_in, 0);
    rst = 1'b0;

    // Matching circuit
    mode = 0;
    run(0, 0, n);
    $display("[TB] sweep good: n=%0d captured=%02h mis=%0d pass=%0d", n, captured, mismatch_count, pass);
    check("good_latency", n, LAT);
    check("good_captured", captured, 8'hB2);
    check("good_mis", mismatch_count, 0);
    check("good_pass", pass, 1);
    check("good_busy_in_done", busy, 0);
    @(negedge clk);
    check("good_done_pulse", done, 0);
    check("good_inputs_idle", row_in, 0);
    repeat (3) @(negedge clk);
    check("idle_captured_hold", captured, 8'hB2);
    check("idle_pass_hold", pass, 1);

    // Stuck-at-0
    mode = 1;
    run(0, 0, n);
    $display("[TB] sweep stuck0: n=%0d captured=%02h mis=%0d pass=%0d", n, captured, mismatch_count, pass);
    check("stuck_latency", n, LAT);
    check("stuck_captured", captured, 8'h00);
    check("stuck_mis", mismatch_count, 4);
    check("stuck_pass", pass, 0);

    // Row 7 inverted
    mode = 2;
    run(0, 0, n);
    $display("[TB] sweep row7: n=%0d captured=%02h mis=%0d pass=%0d", n, captured, mismatch_count, pass);
    check("row7_captured", captured, 8'hB3);
    check("row7_mis", mismatch_count, 1);
    check("row7_pass", pass, 0);

    // Start during sweep is ignored
    mode = 0;
    run(10, 0, n);
    $display("[TB] sweep restart10: n=%0d captured=%02h", n, captured);
    check("restart_latency", n, LAT);
    check("restart_captured", captured, 8'hB2);
    extra_done = 0;
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    check("restart_no_second_sweep", extra_done, 0);

    // Reset mid-sweep (row 4), then a clean sweep
    run(0, 4 * (W + 1) + 2, n);
    $display("[TB] sweep reset_row4: n=%0d busy=%0d captured=%02h", n, busy, captured);
    check("reset_mid_returned", n, -2);
    run(0, 0, n);
    $display("[TB] sweep after_reset: n=%0d captured=%02h pass=%0d", n, captured, pass);
    check("after_reset_latency", n, LAT);
    check("after_reset_captured", captured, 8'hB2);

    // Continuous start: one idle cycle after done, then a new sweep
    @(negedge clk) start = 1'b1;
    n = 0;
    for (int k = 0; k < 200 && !done; k++) @(negedge clk) n++;
    check("cont_done_seen", done, 1);
    @(negedge clk);
    check("cont_idle_gap_busy", busy, 0);
    check("cont_idle_gap_done", done, 0);
    @(negedge clk);
    check("cont_restart_busy", busy, 1);
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 200 && !done; k++) @(negedge clk) n++;
    $display("[TB] sweep continuous: n=%0d captured=%02h pass=%0d", n, captured, pass);
    check("cont_second_done", done, 1);
    check("cont_captured", captured, 8'hB2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
